clock_div_multi: RTL and testbench

CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

---
 rtl/clock_div_defs.sv | 14 +
 rtl/clock_div_channel.sv | 78 +++++++
 rtl/clock_div_multi.sv | 57 +++++
 tb/tb_clock_div_multi.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_defs.sv
// Shared defaults for the clock divider blocks: datapath width and the
// 20 MHz -> 10 kHz reset configuration.
package clock_div_defs;

    localparam int CLK_DIV_WIDTH        = 25;
    localparam int CLK_DIV_DEFAULT_DIV  = 2000;
    localparam int CLK_DIV_DEFAULT_HIGH = 1000;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int clk_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: free-running period counter, registered level/tick
// outputs and a shadow configuration that swaps in only at a period boundary.
module clock_div_channel
    import clock_div_defs::*;
#(
    parameter int WIDTH        = CLK_DIV_WIDTH,
    parameter int DEFAULT_DIV  = CLK_DIV_DEFAULT_DIV,
    parameter int DEFAULT_HIGH = CLK_DIV_DEFAULT_HIGH
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             clock_out,
    output logic             tick,
    output logic             cfg_pending
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_cur;
    logic [WIDTH-1:0] high_cur;
    logic [WIDTH-1:0] div_shadow;
    logic [WIDTH-1:0] high_shadow;
    logic             wrap;

    // Divisors below 2 cannot form a period with both phases, so clamp to 2.
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    always_comb begin
        wrap = (count >= (eff_div(div_cur) - WIDTH'(1)));
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            count       <= '0;
            div_cur     <= WIDTH'(DEFAULT_DIV);
            high_cur    <= WIDTH'(DEFAULT_HIGH);
            div_shadow  <= '0;
            high_shadow <= '0;
            cfg_pending <= 1'b0;
            clock_out   <= 1'b0;
            tick        <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (enable) begin
                // high >= period naturally yields a constant 1, high = 0 a constant 0
                clock_out <= (count < high_cur);
                tick      <= wrap;
                if (wrap) begin
                    count <= '0;
                    if (cfg_pending) begin
                        div_cur     <= div_shadow;
                        high_cur    <= high_shadow;
                        cfg_pending <= 1'b0;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                end
            end else if (cfg_pending) begin
                // A stopped channel has no boundary to wait for: apply and restart.
                count       <= '0;
                div_cur     <= div_shadow;
                high_cur    <= high_shadow;
                cfg_pending <= 1'b0;
            end
            if (cfg_load) begin
                div_shadow  <= cfg_div;
                high_shadow <= cfg_high;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider with a shared configuration port
// that writes per-channel shadow registers.
module clock_div_multi
    import clock_div_defs::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int WIDTH        = CLK_DIV_WIDTH,
    parameter  int DEFAULT_DIV  = CLK_DIV_DEFAULT_DIV,
    parameter  int DEFAULT_HIGH = CLK_DIV_DEFAULT_HIGH,
    localparam int CH_W         = clk_ch_w(NUM_CH)
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic [WIDTH-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    logic [NUM_CH-1:0] cfg_load;

    // Out-of-range channels never match, so they stay ready and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((cfg_ch == CH_W'(i)) && cfg_pending[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign cfg_load[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        clock_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV),
            .DEFAULT_HIGH(DEFAULT_HIGH)
        ) u_channel (
            .clock_in   (clock_in),
            .reset      (reset),
            .enable     (enable[g]),
            .cfg_load   (cfg_load[g]),
            .cfg_div    (cfg_div),
            .cfg_high   (cfg_high),
            .clock_out  (clock_out[g]),
            .tick       (tick[g]),
            .cfg_pending(cfg_pending[g])
        );
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Randomised and directed bench for clock_div_multi with a per-cycle
// scoreboard fed by a behavioural period model.
module tb_clock_div_multi;

    // Five channels give a 3-bit select, so channel 7 is an out-of-range target.
    localparam int NCH   = 5;
    localparam int W     = 25;
    localparam int CHW   = 3;
    localparam int DDIV  = 2000;
    localparam int DHIGH = 1000;

    logic           clock_in  = 1'b0;
    logic           reset     = 1'b1;
    logic [NCH-1:0] enable    = '0;
    logic           cfg_valid = 1'b0;
    logic [CHW-1:0] cfg_ch    = '0;
    logic [W-1:0]   cfg_div   = '0;
    logic [W-1:0]   cfg_high  = '0;
    logic           cfg_ready;
    logic [NCH-1:0] clock_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] cfg_pending;

    int checks   = 0;
    int failures = 0;

    clock_div_multi #(
        .NUM_CH(NCH)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .clock_out  (clock_out),
        .tick       (tick),
        .cfg_pending(cfg_pending)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic [NCH-1:0] co;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] pd;
    } exp_t;

    exp_t sb[$];

    // Model state: position within the current period plus active/shadow settings.
    int m_pos[NCH];
    int m_div[NCH];
    int m_high[NCH];
    int m_sdiv[NCH];
    int m_shigh[NCH];
    bit m_pend[NCH];
    bit m_co[NCH];
    bit m_tk[NCH];

    function automatic int period_of(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    always @(posedge clock_in) begin
        exp_t e;
        bit   acc;
        bit   last;
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                m_pos[i] = 0; m_div[i] = DDIV; m_high[i] = DHIGH;
                m_sdiv[i] = 0; m_shigh[i] = 0; m_pend[i] = 0;
                m_co[i] = 0; m_tk[i] = 0;
            end else begin
                acc = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
                if (enable[i]) begin
                    m_co[i] = (m_pos[i] < m_high[i]);
                    last    = (m_pos[i] == period_of(m_div[i]) - 1);
                    m_tk[i] = last;
                    m_pos[i] = (m_pos[i] + 1) % period_of(m_div[i]);
                    if (last && m_pend[i]) begin
                        m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
                    end
                end else begin
                    m_tk[i] = 0;
                    if (m_pend[i]) begin
                        m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i];
                        m_pend[i] = 0; m_pos[i] = 0;
                    end
                end
                if (acc) begin
                    m_sdiv[i] = int'(cfg_div); m_shigh[i] = int'(cfg_high); m_pend[i] = 1;
                end
            end
            e.co[i] = m_co[i];
            e.tk[i] = m_tk[i];
            e.pd[i] = m_pend[i];
        end
        sb.push_back(e);
    end

    always @(negedge clock_in) begin
        exp_t e;
        logic exp_ready;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_ready = 1'b1;
            if (int'(cfg_ch) < NCH) exp_ready = !e.pd[cfg_ch];
            checks++;
            if ({clock_out, tick, cfg_pending, cfg_ready} !== {e.co, e.tk, e.pd, exp_ready}) begin
                failures++;
                $display("FAIL scoreboard t=%0t clock_out=%b/%b tick=%b/%b pending=%b/%b ready=%b/%b (actual/expected)",
                         $time, clock_out, e.co, tick, e.tk, cfg_pending, e.pd, cfg_ready, exp_ready);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int d, input int h);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = W'(d);
        cfg_high  = W'(h);
        step();
        cfg_valid = 1'b0;
    endtask

    // Configure through the stopped-channel path, then start the channel.
    task automatic setup_stopped(input int ch, input int d, input int h);
        enable[ch] = 1'b0;
        step();
        cfg_write(ch, d, h);
        step();
        step();
        enable[ch] = 1'b1;
        repeat (4) step();
    endtask

    task automatic count_window(input int ch, input int n, output int hi, output int tk);
        hi = 0;
        tk = 0;
        repeat (n) begin
            @(negedge clock_in);
            hi += int'(clock_out[ch]);
            tk += int'(tick[ch]);
        end
    endtask

    initial begin
        int hi, tk, n, lvl;

        repeat (3) step();
        @(negedge clock_in);
        check("reset_clock_out", int'(clock_out), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_pending", int'(cfg_pending), 0);
        step();
        reset = 1'b0;

        setup_stopped(0, 10, 3);
        repeat (10) step();
        count_window(0, 10, hi, tk);
        check("ch0_d10h3_high", hi, 3);
        check("ch0_d10h3_tick", tk, 1);
        count_window(0, 20, hi, tk);
        check("ch0_d10h3_high_2p", hi, 6);
        check("ch0_d10h3_tick_2p", tk, 2);

        setup_stopped(1, 10, 5);
        repeat (3) step();
        cfg_write(1, 4, 2);
        @(negedge clock_in);
        check("ch1_pending_set", int'(cfg_pending[1]), 1);
        check("ch1_ready_low", int'(cfg_ready), 0);
        n = 0;
        do begin
            @(negedge clock_in);
            n++;
            if (cfg_pending[1]) check("ch1_ready_held_low", int'(cfg_ready), 0);
        end while (cfg_pending[1] && n < 30);
        check("ch1_apply_timeout", int'(cfg_pending[1]), 0);
        count_window(1, 8, hi, tk);
        check("ch1_d4h2_high", hi, 4);
        check("ch1_d4h2_tick", tk, 2);

        setup_stopped(2, 1, 1);
        count_window(2, 8, hi, tk);
        check("ch2_div1_high", hi, 4);
        check("ch2_div1_tick", tk, 4);
        setup_stopped(2, 0, 1);
        count_window(2, 8, hi, tk);
        check("ch2_div0_high", hi, 4);
        check("ch2_div0_tick", tk, 4);

        setup_stopped(3, 8, 0);
        count_window(3, 16, hi, tk);
        check("ch3_high0_level", hi, 0);
        check("ch3_high0_tick", tk, 2);
        setup_stopped(3, 8, 12);
        count_window(3, 16, hi, tk);
        check("ch3_high12_level", hi, 16);
        check("ch3_high12_tick", tk, 2);

        setup_stopped(2, 10, 5);
        repeat (3) step();
        enable[2] = 1'b0;
        @(negedge clock_in);
        lvl = int'(clock_out[2]);
        repeat (5) begin
            @(negedge clock_in);
            check("ch2_frozen_level", int'(clock_out[2]), lvl);
            check("ch2_frozen_tick", int'(tick[2]), 0);
        end
        enable[2] = 1'b1;
        repeat (3) step();
        count_window(2, 10, hi, tk);
        check("ch2_resume_high", hi, 5);
        check("ch2_resume_tick", tk, 1);

        cfg_write(7, 3, 1);
        @(negedge clock_in);
        check("ch7_no_pending", int'(cfg_pending), 0);
        check("ch7_ready", int'(cfg_ready), 1);

        step();
        enable[4] = 1'b1;
        step();
        cfg_write(4, 5, 2);
        @(negedge clock_in);
        check("ch4_pending_before_reset", int'(cfg_pending[4]), 1);
        step();
        reset     = 1'b1;
        enable    = '1;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd3;
        step();
        @(negedge clock_in);
        check("rst_mid_clock_out", int'(clock_out), 0);
        check("rst_mid_tick", int'(tick), 0);
        check("rst_mid_pending", int'(cfg_pending), 0);
        step();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        enable    = 5'b00001;
        cfg_ch    = 3'd4;
        @(negedge clock_in);
        check("ready_after_reset", int'(cfg_ready), 1);
        repeat (5) step();
        count_window(0, DDIV, hi, tk);
        check("default_period_high", hi, DHIGH);
        check("default_period_tick", tk, 1);

        repeat (3000) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NCH; i++) enable[i] = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = CHW'($urandom_range(0, 7));
            cfg_div   = W'($urandom_range(0, 12));
            cfg_high  = W'($urandom_range(0, 14));
            step();
        end
        reset     = 1'b0;
        cfg_valid = 1'b0;
        repeat (3) step();
        @(negedge clock_in);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
